// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// returns {remainder, quotient} for the HI/LO write and stalls EX while iterating.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic             neg_quot_reg;
  logic             neg_rem_reg;

  logic             accept;
  logic             div_zero;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             last_iter;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_next;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quot_fix;

  assign accept    = start_i & ~annul_i;
  assign div_zero  = (opdata2_i == '0);
  assign a_neg     = signed_i & opdata1_i[WIDTH-1];
  assign b_neg     = signed_i & opdata2_i[WIDTH-1];
  assign a_abs     = a_neg ? (~opdata1_i + 1'b1) : opdata1_i;
  assign b_abs     = b_neg ? (~opdata2_i + 1'b1) : opdata2_i;
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));

  // Partial remainder is always below the divisor, so the shifted value fits in
  // WIDTH+1 bits; bit WIDTH of the difference is the borrow (rem < dvs).
  assign rem_shift = {rem_reg, dvd_reg[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, dvs_reg};
  assign qbit      = ~diff[WIDTH];
  assign rem_next  = qbit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quot_next = {dvd_reg[WIDTH-2:0], qbit};
  assign quot_fix  = neg_quot_reg ? (~quot_next + 1'b1) : quot_next;
  assign rem_fix   = neg_rem_reg  ? (~rem_next  + 1'b1) : rem_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = div_zero ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        state_next = annul_i ? S_IDLE : S_END;
      end
      S_ON: begin
        if (annul_i) begin
          state_next = S_IDLE;
        end else if (last_iter) begin
          state_next = S_END;
        end
      end
      S_END: begin
        if (annul_i || !start_i) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o  = 1'b0;
    ready_o = 1'b0;
    case (state_reg)
      S_IDLE:   busy_o  = accept;
      S_BYZERO: busy_o  = 1'b1;
      S_ON:     busy_o  = 1'b1;
      S_END:    ready_o = 1'b1;
      default: begin
        busy_o  = 1'b0;
        ready_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg      <= '0;
      rem_reg      <= '0;
      dvd_reg      <= '0;
      dvs_reg      <= '0;
      neg_quot_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
      result_o     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            cnt_reg <= '0;
            rem_reg <= '0;
            if (div_zero) begin
              // Raw dividend is kept so the divide-by-zero result can return it as-is.
              dvd_reg <= opdata1_i;
            end else begin
              dvd_reg      <= a_abs;
              dvs_reg      <= b_abs;
              neg_quot_reg <= a_neg ^ b_neg;
              neg_rem_reg  <= a_neg;
            end
          end
        end
        S_ON: begin
          if (!annul_i) begin
            rem_reg <= rem_next;
            dvd_reg <= quot_next;
            cnt_reg <= cnt_reg + CW'(1);
            if (last_iter) begin
              result_o <= {rem_fix, quot_fix};
            end
          end
        end
        S_BYZERO: begin
          if (!annul_i) begin
            result_o <= {dvd_reg, {WIDTH{1'b1}}};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: driver pushes the hand-computed result into a
// scoreboard queue, a negedge monitor pops and compares on each ready_o rise.
module tb_div_iter;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        sgn;
  logic        annul;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  logic [63:0] sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        ready_prev = 1'b0;
  logic [63:0] last_exp = 64'd0;

  div_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start_i   (start),
    .signed_i  (sgn),
    .annul_i   (annul),
    .opdata1_i (opa),
    .opdata2_i (opb),
    .result_o  (result),
    .ready_o   (ready),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: one pop per rising ready_o
  always @(negedge clk) begin
    if (ready && !ready_prev) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got %h, expected no result", result);
      end else begin
        logic [63:0] exp;
        exp = sb_q.pop_front();
        chk("result", result, exp);
        $display("result %h (expected %h)", result, exp);
      end
    end
    ready_prev <= ready;
  end

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [63:0] exp, input int lat);
    int   n;
    logic got;
    logic busy_ok;
    sb_q.push_back(exp);
    last_exp = exp;
    @(posedge clk); #1;
    opa = a; opb = b; sgn = s; start = 1'b1;
    @(negedge clk);
    chk("busy_accept", busy, 1);
    n = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        // operands must be ignored after acceptance
        opa = ~a; opb = a ^ b ^ 32'h5a5a_0001; sgn = ~s;
      end
      @(negedge clk);
      if (ready) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    chk("ready_seen", got, 1);
    chk("latency", n, lat);
    chk("busy_during", busy_ok, 1);
    chk("busy_end", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("hold_end", ready, 1);
    @(negedge clk);
    chk("back_idle", ready, 0);
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint      sa, sb, q, r;
    logic [63:0] q64, r64;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      q64 = q; r64 = r;
      return {r64[31:0], q64[31:0]};
    end
    return {a % b, a / b};
  endfunction

  initial begin
    resetn = 1'b0; start = 1'b0; sgn = 1'b0; annul = 1'b0;
    opa = 32'd0; opb = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_result", result, 64'd0);
    chk("reset_ready", ready, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    run(32'd7,         32'd2,         1'b0, {32'd1, 32'd3}, 33);
    run(32'hFFFF_FFF9, 32'd2,         1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run(32'd7,         32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 33);
    run(32'hFFFF_FFFF, 32'd1,         1'b0, {32'd0, 32'hFFFF_FFFF}, 33);
    run(32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, {32'hFFFF_FFFE, 32'd2}, 33);
    run(32'd5,         32'd10,        1'b0, {32'd5, 32'd0}, 33);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'd0, 32'd1}, 33);
    run(32'h8000_0000, 32'd2,         1'b1, {32'd0, 32'hC000_0000}, 33);
    run(32'h0000_1234, 32'd0,         1'b0, {32'h0000_1234, 32'hFFFF_FFFF}, 2);
    run(32'h8000_0000, 32'd0,         1'b1, {32'h8000_0000, 32'hFFFF_FFFF}, 2);

    // annul mid-divide: back to IDLE, nothing delivered, result held
    @(posedge clk); #1;
    opa = 32'd50; opb = 32'd3; sgn = 1'b0; start = 1'b1;
    repeat (10) @(posedge clk);
    #1; annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    @(negedge clk);
    chk("annul_busy", busy, 0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (ready) seen = 1'b1;
      end
      chk("annul_no_ready", seen, 0);
      chk("annul_result_held", result, last_exp);
    end
    run(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);

    // start and annul together in IDLE: nothing accepted
    @(posedge clk); #1;
    opa = 32'd9; opb = 32'd4; start = 1'b1; annul = 1'b1;
    @(negedge clk);
    chk("start_annul_busy", busy, 0);
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    chk("start_annul_idle", busy, 0);

    // async reset mid-divide
    @(posedge clk); #1;
    opa = 32'd1000; opb = 32'd3; sgn = 1'b0; start = 1'b1;
    repeat (5) @(posedge clk);
    #1; resetn = 1'b0; start = 1'b0;
    #1;
    chk("midreset_result", result, 64'd0);
    chk("midreset_ready", ready, 0);
    chk("midreset_busy", busy, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    for (int i = 0; i < 30; i++) begin
      logic [31:0] a, b;
      logic        s;
      a = $urandom();
      b = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom();
      s = 1'($urandom_range(0, 1));
      run(a, b, s, model(a, b, s), (b == 32'd0) ? 2 : 33);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
